if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS core: holds the PC, selects the next PC, and drives the IF/ID pipeline register feeding the decode stage. It consumes the hazard unit's `PC_Write` and `IF_ID_Write` stall controls and the decode stage's redirect (branch/jump/jr) and flush requests. It also keeps a saturating stall-length counter with a sticky timeout flag for debug of hazard-unit deadlock.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `CW`, 4, width of stall counter.
- `STALL_LIMIT`, 15, consecutive stall cycles that raise `Stall_Timeout`; legal range 1 .. 2^CW-1.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PC_Write`  in  1  from hazard unit; 0 = hold PC.
- `IF_ID_Write`  in  1  from hazard unit; 0 = hold IF/ID register.
- `IF_Flush`  in  1  from ID; squash instruction being fetched (taken branch/jump).
- `PC_Src`  in  2  next-PC select: 00 PC+4, 01 `Branch_Target`, 10 `Jump_Target`, 11 `Jr_Target`.
- `Branch_Target`  in  32  branch target computed in ID.
- `Jump_Target`  in  32  j/jal target formed in ID.
- `Jr_Target`  in  32  register value for jr.
- `Inst_In`  in  32  instruction-memory read data for `Inst_Addr`, same cycle.
- `Inst_Addr`  out  32  current PC to instruction memory.
- `IF_ID_Inst`  out  32  instruction to ID.
- `IF_ID_PC4`  out  32  PC+4 of that instruction.
- `IF_ID_Valid`  out  1  1 = real instruction, 0 = bubble.
- `Stall_Count`  out  CW  current consecutive-stall count.
- `Stall_Timeout`  out  1  sticky: stall reached `STALL_LIMIT`.

## Operation
- Reset (async on `rst_n`=0, held until release): PC=`RESET_PC`, `IF_ID_Inst`=0, `IF_ID_PC4`=0, `IF_ID_Valid`=0, `Stall_Count`=0, `Stall_Timeout`=0. All state registered; reset mid-stall or mid-redirect discards everything.
- `Inst_Addr` = PC register directly (no combinational path from inputs).
- Next PC, per `PC_Src`: PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), or the selected target with bits [1:0] forced to 00.
- PC update on edge: `PC_Write`=1 → PC ← next PC; `PC_Write`=0 → PC holds, `PC_Src` ignored (stall dominates redirect; the stalled ID instruction re-issues it).
- IF/ID update on edge, priority order:
  - `IF_ID_Write`=0 → hold all three fields; `IF_Flush` ignored.
  - `IF_Flush`=1 → `IF_ID_Inst`←0 (NOP), `IF_ID_PC4`←PC+4, `IF_ID_Valid`←0.
  - else → `IF_ID_Inst`←`Inst_In`, `IF_ID_PC4`←PC+4, `IF_ID_Valid`←1.
- `PC_Write`=1 with `IF_ID_Write`=0 is legal and honoured independently (the instruction at the old PC is lost; the hazard unit never requests this).
- Stall counter FSM, two states, IDLE (count 0) / STALLING (count>0):
  - edge with `PC_Write`=0: count ← count+1, saturating at 2^CW-1.
  - edge with `PC_Write`=1: count ← 0.
  - `Stall_Timeout` set on the edge where count becomes `STALL_LIMIT`; cleared only by reset.

## Timing
- Redirect latency 1 cycle: `PC_Src`≠00 with `PC_Write`=1 at edge N → `Inst_Addr`=target after N.
- Fetch-to-decode latency 1 cycle: `Inst_In` sampled at edge N appears on `IF_ID_Inst` after N.
- A one-cycle hazard stall (`PC_Write`=`IF_ID_Write`=0 for one cycle) holds PC and IF/ID for exactly one edge; nothing is lost or duplicated.
- `Stall_Count` and `Stall_Timeout` change only on edges; `Stall_Timeout` is asserted after the `STALL_LIMIT`-th consecutive stall edge.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, free-run 3 cycles, `PC_Src`=00 → `Inst_Addr` 0040_0000, 0040_0004, 0040_0008; `IF_ID_Valid` 0 then 1; `IF_ID_PC4`=0040_0004 after first edge.
- Load-use stall: drop `PC_Write`/`IF_ID_Write` for 1 cycle at PC 0x10 → PC stays 0x10 for 2 cycles, `IF_ID_Inst` unchanged for one edge, `Stall_Count` 1 then 0.
- Taken branch: `PC_Src`=01, `Branch_Target`=0x0000_0103, `IF_Flush`=1 → next `Inst_Addr`=0x100, `IF_ID_Inst`=0, `IF_ID_Valid`=0.
- Stall dominates: `PC_Write`=0, `IF_ID_Write`=0, `PC_Src`=11, `IF_Flush`=1 → PC and IF/ID unchanged.
- Wrap: PC=0xFFFF_FFFC, `PC_Src`=00 → `Inst_Addr`=0, `IF_ID_PC4`=0.
- Timeout: hold `PC_Write`=0 for 20 cycles → `Stall_Count` saturates at 15, `Stall_Timeout` rises after the 15th edge and stays 1 after `PC_Write` returns; async `rst_n` pulse mid-stall clears all outputs immediately.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls in,
// IF/ID register, PC and stall debug status out.
interface if_stage_if #(
  parameter int CW = 4
);
  logic          PC_Write;
  logic          IF_ID_Write;
  logic          IF_Flush;
  logic [1:0]    PC_Src;
  logic [31:0]   Branch_Target;
  logic [31:0]   Jump_Target;
  logic [31:0]   Jr_Target;
  logic [31:0]   Inst_In;
  logic [31:0]   Inst_Addr;
  logic [31:0]   IF_ID_Inst;
  logic [31:0]   IF_ID_PC4;
  logic          IF_ID_Valid;
  logic [CW-1:0] Stall_Count;
  logic          Stall_Timeout;

  modport master (
    output PC_Write, IF_ID_Write, IF_Flush,
    output PC_Src, Branch_Target,
    output Jump_Target, Jr_Target, Inst_In,
    input  Inst_Addr, IF_ID_Inst, IF_ID_PC4,
    input  IF_ID_Valid, Stall_Count,
    input  Stall_Timeout
  );

  modport slave (
    input  PC_Write, IF_ID_Write, IF_Flush,
    input  PC_Src, Branch_Target,
    input  Jump_Target, Jr_Target, Inst_In,
    output Inst_Addr, IF_ID_Inst, IF_ID_PC4,
    output IF_ID_Valid, Stall_Count,
    output Stall_Timeout
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select,
// IF/ID pipeline register and stall-length watchdog.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CW          = 4,
  parameter int          STALL_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.slave  bus
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  typedef enum logic {
    IDLE,
    STALLING
  } st_t;

  localparam logic [CW-1:0] LIM = STALL_LIMIT[CW-1:0];
  localparam logic [CW-1:0] SAT = '1;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] pc_nx;
  if_id_t      if_id;

  st_t           st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          tmo, tmo_nx;

  assign pc4 = pc + 32'd4;

  // Redirect targets are word-aligned by dropping the low two bits.
  always_comb begin
    pc_nx = pc4;
    unique case (bus.PC_Src)
      2'b00: pc_nx = pc4;
      2'b01: pc_nx = bus.Branch_Target & ~32'h3;
      2'b10: pc_nx = bus.Jump_Target & ~32'h3;
      2'b11: pc_nx = bus.Jr_Target & ~32'h3;
      default: pc_nx = pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (bus.PC_Write) begin
      pc <= pc_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id <= '0;
    end else if (bus.IF_ID_Write) begin
      if (bus.IF_Flush) begin
        if_id.inst  <= 32'h0;
        if_id.pc4   <= pc4;
        if_id.valid <= 1'b0;
      end else begin
        if_id.inst  <= bus.Inst_In;
        if_id.pc4   <= pc4;
        if_id.valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      tmo <= tmo_nx;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    unique case (st)
      IDLE: begin
        if (!bus.PC_Write) begin
          st_nx  = STALLING;
          cnt_nx = ONE;
        end
      end
      STALLING: begin
        if (bus.PC_Write) begin
          st_nx  = IDLE;
          cnt_nx = '0;
        end else if (cnt != SAT) begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        st_nx  = IDLE;
        cnt_nx = '0;
      end
    endcase
    tmo_nx = tmo | (!bus.PC_Write && cnt_nx == LIM);
  end

  assign bus.Inst_Addr     = pc;
  assign bus.IF_ID_Inst    = if_id.inst;
  assign bus.IF_ID_PC4     = if_id.pc4;
  assign bus.IF_ID_Valid   = if_id.valid;
  assign bus.Stall_Count   = cnt;
  assign bus.Stall_Timeout = tmo;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, watchdog
// sequence, then random traffic against a reference model.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int CW  = 4;
  localparam int LIM = 15;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  if_stage_if #(.CW(CW)) bus ();

  if_stage #(
    .RESET_PC(RPC),
    .CW(CW),
    .STALL_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        fl;
    logic [1:0]  src;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] jrt;
    logic [31:0] inst;
    logic [31:0] ea;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        ev;
    logic [3:0]  ec;
    logic        et;
  } vec_t;

  vec_t tv[11];

  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_v, m_tmo;
  int          m_run;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic iw,
                       input logic fl, input logic [1:0] src,
                       input logic [31:0] bt,
                       input logic [31:0] jt,
                       input logic [31:0] jrt,
                       input logic [31:0] inst);
    bus.PC_Write      = pw;
    bus.IF_ID_Write   = iw;
    bus.IF_Flush      = fl;
    bus.PC_Src        = src;
    bus.Branch_Target = bt;
    bus.Jump_Target   = jt;
    bus.Jr_Target     = jrt;
    bus.Inst_In       = inst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc   = RPC;
    m_inst = '0;
    m_pc4  = '0;
    m_v    = 1'b0;
    m_run  = 0;
    m_tmo  = 1'b0;
  endtask

  // Abstract model: unbounded stall run length, clamped only on compare.
  task automatic model_step();
    logic [31:0] old, nx;
    old = m_pc;
    case (bus.PC_Src)
      2'd1:    nx = bus.Branch_Target & ~32'h3;
      2'd2:    nx = bus.Jump_Target & ~32'h3;
      2'd3:    nx = bus.Jr_Target & ~32'h3;
      default: nx = old + 32'd4;
    endcase
    if (bus.PC_Write) m_pc = nx;
    if (bus.IF_ID_Write) begin
      m_inst = bus.IF_Flush ? 32'h0 : bus.Inst_In;
      m_pc4  = old + 32'd4;
      m_v    = !bus.IF_Flush;
    end
    m_run = bus.PC_Write ? 0 : m_run + 1;
    if (m_run >= LIM) m_tmo = 1'b1;
  endtask

  task automatic check_model(input string tag);
    int ec;
    ec = (m_run > SAT) ? SAT : m_run;
    chk({tag, ".addr"}, bus.Inst_Addr, m_pc);
    chk({tag, ".inst"}, bus.IF_ID_Inst, m_inst);
    chk({tag, ".pc4"}, bus.IF_ID_PC4, m_pc4);
    chk({tag, ".valid"}, 32'(bus.IF_ID_Valid), 32'(m_v));
    chk({tag, ".cnt"}, 32'(bus.Stall_Count), 32'(ec));
    chk({tag, ".tmo"}, 32'(bus.Stall_Timeout), 32'(m_tmo));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".addr"}, bus.Inst_Addr, RPC);
    chk({tag, ".inst"}, bus.IF_ID_Inst, 32'h0);
    chk({tag, ".pc4"}, bus.IF_ID_PC4, 32'h0);
    chk({tag, ".valid"}, 32'(bus.IF_ID_Valid), 32'h0);
    chk({tag, ".cnt"}, 32'(bus.Stall_Count), 32'h0);
    chk({tag, ".tmo"}, 32'(bus.Stall_Timeout), 32'h0);
  endtask

  initial begin
    tv[0]  = '{1,1,0,2'd0,0,0,0,32'hA1,
               32'h0040_0004,32'hA1,32'h0040_0004,1,0,0};
    tv[1]  = '{1,1,0,2'd0,0,0,0,32'hA2,
               32'h0040_0008,32'hA2,32'h0040_0008,1,0,0};
    tv[2]  = '{0,0,1,2'd3,0,0,32'h1234_5678,32'hA3,
               32'h0040_0008,32'hA2,32'h0040_0008,1,1,0};
    tv[3]  = '{1,1,0,2'd0,0,0,0,32'hA3,
               32'h0040_000C,32'hA3,32'h0040_000C,1,0,0};
    tv[4]  = '{1,1,1,2'd1,32'h0000_0103,0,0,32'hB0,
               32'h0000_0100,32'h0,32'h0040_0010,0,0,0};
    tv[5]  = '{1,1,0,2'd2,0,32'h0000_2002,0,32'hC0,
               32'h0000_2000,32'hC0,32'h0000_0104,1,0,0};
    tv[6]  = '{1,1,0,2'd3,0,0,32'hFFFF_FFFF,32'hD0,
               32'hFFFF_FFFC,32'hD0,32'h0000_2004,1,0,0};
    tv[7]  = '{1,1,0,2'd0,0,0,0,32'hE0,
               32'h0,32'hE0,32'h0,1,0,0};
    tv[8]  = '{1,0,0,2'd0,0,0,0,32'hF0,
               32'h4,32'hE0,32'h0,1,0,0};
    tv[9]  = '{0,1,0,2'd0,0,0,0,32'h60,
               32'h4,32'h60,32'h8,1,1,0};
    tv[10] = '{1,1,0,2'd0,0,0,0,32'h70,
               32'h8,32'h70,32'h8,1,0,0};

    drive(1, 1, 0, 2'd0, 0, 0, 0, 0);
    #11;
    check_reset("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].pw, tv[i].iw, tv[i].fl, tv[i].src,
            tv[i].bt, tv[i].jt, tv[i].jrt, tv[i].inst);
      tick();
      chk($sformatf("v%0d.addr", i), bus.Inst_Addr, tv[i].ea);
      chk($sformatf("v%0d.inst", i), bus.IF_ID_Inst, tv[i].ei);
      chk($sformatf("v%0d.pc4", i), bus.IF_ID_PC4, tv[i].ep);
      chk($sformatf("v%0d.valid", i),
          32'(bus.IF_ID_Valid), 32'(tv[i].ev));
      chk($sformatf("v%0d.cnt", i),
          32'(bus.Stall_Count), 32'(tv[i].ec));
      chk($sformatf("v%0d.tmo", i),
          32'(bus.Stall_Timeout), 32'(tv[i].et));
    end

    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 2'd0, 0, 0, 0, 32'hDEAD);
      tick();
      chk($sformatf("to%0d.addr", i), bus.Inst_Addr, 32'h8);
      chk($sformatf("to%0d.cnt", i), 32'(bus.Stall_Count),
          32'((i > SAT) ? SAT : i));
      chk($sformatf("to%0d.tmo", i), 32'(bus.Stall_Timeout),
          32'(i >= LIM));
    end
    drive(1, 1, 0, 2'd0, 0, 0, 0, 32'h80);
    tick();
    chk("to_rel.addr", bus.Inst_Addr, 32'hC);
    chk("to_rel.cnt", 32'(bus.Stall_Count), 32'h0);
    chk("to_rel.tmo", 32'(bus.Stall_Timeout), 32'h1);

    drive(0, 0, 0, 2'd0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    begin
      int lng = 0;
      logic pw, iw;
      for (int i = 0; i < 500; i++) begin
        if (lng > 0) begin
          pw = 1'b0;
          lng--;
        end else begin
          pw = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 39) == 0)
            lng = $urandom_range(10, 20);
        end
        iw = ($urandom_range(0, 7) == 0) ?
             1'($urandom_range(0, 1)) : pw;
        drive(pw, iw, ($urandom_range(0, 5) == 0),
              2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom, $urandom);
        model_step();
        tick();
        check_model($sformatf("r%0d", i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
